// File: rtl/cpu8080_pkg.sv
// Shared 8080 front-end definitions: opcode constants, length and state encodings.
package cpu8080_pkg;

  localparam logic [7:0] OP_HLT      = 8'h76;
  localparam logic [7:0] OP_EI       = 8'hFB;
  localparam logic [7:0] OP_DI       = 8'hF3;
  localparam logic [7:0] OP_RST_BASE = 8'hC7;

  // Encoded value equals the byte count so it can be added to the PC directly.
  typedef enum logic [1:0] {
    LEN1 = 2'd1,
    LEN2 = 2'd2,
    LEN3 = 2'd3
  } len_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

endpackage

// File: rtl/instr_len.sv
// Combinational 8080 opcode-to-instruction-length decode.
module instr_len
  import cpu8080_pkg::*;
(
  input  logic [7:0] opcode_i,
  output len_e       len_o
);

  logic is_len3;
  logic is_len2;

  // Classify by the opcode bit patterns of the multi-byte instruction groups.
  always_comb begin
    is_len3 = 1'b0;
    is_len2 = 1'b0;
    // LXI rp
    if (opcode_i[7:6] == 2'b00 && opcode_i[3:0] == 4'b0001) is_len3 = 1'b1;
    // SHLD, LHLD, STA, LDA, JMP, CALL
    if (opcode_i == 8'h22 || opcode_i == 8'h2A || opcode_i == 8'h32 ||
        opcode_i == 8'h3A || opcode_i == 8'hC3 || opcode_i == 8'hCD) is_len3 = 1'b1;
    // Jccc and Cccc
    if (opcode_i[7:6] == 2'b11 &&
        (opcode_i[2:0] == 3'b010 || opcode_i[2:0] == 3'b100)) is_len3 = 1'b1;
    // MVI r and the ALU-immediate group share the low bits 110
    if ((opcode_i[7:6] == 2'b00 || opcode_i[7:6] == 2'b11) &&
        opcode_i[2:0] == 3'b110) is_len2 = 1'b1;
    // OUT, IN
    if (opcode_i == 8'hD3 || opcode_i == 8'hDB) is_len2 = 1'b1;
  end

  // Select the final length; the groups are disjoint.
  always_comb begin
    if (is_len3) begin
      len_o = LEN3;
    end else if (is_len2) begin
      len_o = LEN2;
    end else begin
      len_o = LEN1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// 8080 fetch front end: owns the PC, sizes and dispatches one instruction per cycle,
// applies redirects, handles HLT and injects RST n for interrupts.
module fetch_sequencer
  import cpu8080_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] fetch_addr,
  input  logic [23:0] fetch_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        int_req,
  input  logic [2:0]  int_vec,
  output logic        int_ack,
  output logic        d_valid,
  output logic [23:0] d_instruction,
  output logic [15:0] d_pc,
  output logic [1:0]  d_len,
  output logic        inte,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        inte_q, inte_d;
  logic        ei_pending_q, ei_pending_d;
  logic        int_ack_q, int_ack_d;
  logic        d_valid_q, d_valid_d;
  logic [23:0] d_instr_q, d_instr_d;
  logic [15:0] d_pc_q, d_pc_d;
  logic [1:0]  d_len_q, d_len_d;

  logic [7:0]  opcode;
  len_e        len;
  logic [23:0] masked_instr;
  logic [23:0] rst_instr;

  assign opcode = fetch_data[23:16];

  instr_len u_instr_len (
    .opcode_i (opcode),
    .len_o    (len)
  );

  // Zero the bytes that do not belong to the current instruction.
  always_comb begin
    unique case (len)
      LEN1:    masked_instr = {opcode, 16'h0000};
      LEN2:    masked_instr = {fetch_data[23:8], 8'h00};
      default: masked_instr = fetch_data;
    endcase
  end

  assign rst_instr = {OP_RST_BASE | {2'b00, int_vec, 3'b000}, 16'h0000};

  // Next-state: redirect > stall > interrupt > normal dispatch / halt idle.
  always_comb begin
    pc_d         = pc_q;
    state_d      = state_q;
    inte_d       = inte_q;
    ei_pending_d = ei_pending_q;
    int_ack_d    = 1'b0;
    d_valid_d    = d_valid_q;
    d_instr_d    = d_instr_q;
    d_pc_d       = d_pc_q;
    d_len_d      = d_len_q;

    if (redirect) begin
      // Flush; also cancels a HLT that was fetched down the wrong path.
      pc_d      = redirect_pc;
      d_valid_d = 1'b0;
      state_d   = RUN;
    end else if (stall) begin
      // Hold everything; int_ack already defaulted low.
    end else if (inte_q && int_req) begin
      // Inject RST n; d_pc carries the return address, PC is not advanced.
      d_instr_d    = rst_instr;
      d_pc_d       = pc_q;
      d_len_d      = 2'd1;
      d_valid_d    = 1'b1;
      inte_d       = 1'b0;
      ei_pending_d = 1'b0;
      int_ack_d    = 1'b1;
      state_d      = RUN;
    end else if (state_q == RUN) begin
      d_instr_d = masked_instr;
      d_pc_d    = pc_q;
      d_len_d   = len;
      d_valid_d = 1'b1;
      pc_d      = pc_q + {14'd0, len};
      // An EI from the previous dispatch takes effect now, one instruction late.
      if (ei_pending_q) begin
        inte_d = 1'b1;
      end
      ei_pending_d = (opcode == OP_EI);
      if (opcode == OP_DI) begin
        inte_d       = 1'b0;
        ei_pending_d = 1'b0;
      end
      if (opcode == OP_HLT) begin
        state_d = HALT;
      end
    end else begin
      d_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      inte_q       <= 1'b0;
      ei_pending_q <= 1'b0;
      int_ack_q    <= 1'b0;
      d_valid_q    <= 1'b0;
      d_instr_q    <= 24'h000000;
      d_pc_q       <= 16'h0000;
      d_len_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inte_q       <= inte_d;
      ei_pending_q <= ei_pending_d;
      int_ack_q    <= int_ack_d;
      d_valid_q    <= d_valid_d;
      d_instr_q    <= d_instr_d;
      d_pc_q       <= d_pc_d;
      d_len_q      <= d_len_d;
    end
  end

  assign fetch_addr    = pc_q;
  assign int_ack       = int_ack_q;
  assign d_valid       = d_valid_q;
  assign d_instruction = d_instr_q;
  assign d_pc          = d_pc_q;
  assign d_len         = d_len_q;
  assign inte          = inte_q;
  assign halted        = (state_q == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic,
// all compared against an instruction-level reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fetch_addr;
  logic [23:0] fetch_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        int_req;
  logic [2:0]  int_vec;
  logic        int_ack;
  logic        d_valid;
  logic [23:0] d_instruction;
  logic [15:0] d_pc;
  logic [1:0]  d_len;
  logic        inte;
  logic        halted;

  logic [7:0]  mem [0:65535];
  logic [15:0] fa1, fa2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [15:0] m_pc, m_dpc;
  logic [23:0] m_di;
  logic [1:0]  m_dlen;
  logic        m_halt, m_inte, m_eip, m_dv, m_ack;

  always #5 clk = ~clk;

  assign fa1 = fetch_addr + 16'd1;
  assign fa2 = fetch_addr + 16'd2;
  assign fetch_data = {mem[fetch_addr], mem[fa1], mem[fa2]};

  fetch_sequencer #(
    .RESET_PC (16'hFFFE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_addr    (fetch_addr),
    .fetch_data    (fetch_data),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .int_req       (int_req),
    .int_vec       (int_vec),
    .int_ack       (int_ack),
    .d_valid       (d_valid),
    .d_instruction (d_instruction),
    .d_pc          (d_pc),
    .d_len         (d_len),
    .inte          (inte),
    .halted        (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction length from the 8080 opcode tables, listed explicitly.
  function automatic int unsigned ref_len(input logic [7:0] op);
    if (op inside {8'h01, 8'h11, 8'h21, 8'h31, 8'h22, 8'h2A, 8'h32, 8'h3A, 8'hC3, 8'hCD,
                   8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hE2, 8'hEA, 8'hF2, 8'hFA,
                   8'hC4, 8'hCC, 8'hD4, 8'hDC, 8'hE4, 8'hEC, 8'hF4, 8'hFC})
      return 3;
    if (op inside {8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                   8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hD3, 8'hDB})
      return 2;
    return 1;
  endfunction

  task automatic model_reset();
    m_pc = 16'hFFFE; m_dpc = 16'h0; m_di = 24'h0; m_dlen = 2'd0;
    m_halt = 1'b0; m_inte = 1'b0; m_eip = 1'b0; m_dv = 1'b0; m_ack = 1'b0;
  endtask

  // One clock edge of architectural behaviour given the current inputs.
  task automatic model_step();
    logic [7:0]  op;
    int unsigned len;
    logic [15:0] a1, a2;
    m_ack = 1'b0;
    if (redirect) begin
      m_pc = redirect_pc; m_dv = 1'b0; m_halt = 1'b0;
    end else if (stall) begin
      m_ack = 1'b0;
    end else if (m_inte && int_req) begin
      m_di   = {8'(8'hC7 + 8 * int_vec), 16'h0000};
      m_dpc  = m_pc; m_dlen = 2'd1; m_dv = 1'b1;
      m_inte = 1'b0; m_eip = 1'b0; m_ack = 1'b1; m_halt = 1'b0;
    end else if (!m_halt) begin
      a1  = m_pc + 16'd1;
      a2  = m_pc + 16'd2;
      op  = mem[m_pc];
      len = ref_len(op);
      m_di   = {op, (len > 1) ? mem[a1] : 8'h00, (len > 2) ? mem[a2] : 8'h00};
      m_dpc  = m_pc; m_dlen = 2'(len); m_dv = 1'b1;
      m_pc   = 16'((32'(m_pc) + len) % 65536);
      if (op == 8'hF3) begin
        m_inte = 1'b0; m_eip = 1'b0;
      end else begin
        if (m_eip) m_inte = 1'b1;
        m_eip = (op == 8'hFB);
      end
      if (op == 8'h76) m_halt = 1'b1;
    end else begin
      m_dv = 1'b0;
    end
  endtask

  task automatic check_all();
    check("fetch_addr", fetch_addr, m_pc);
    check("d_valid", d_valid, m_dv);
    check("d_instruction", d_instruction, m_di);
    check("d_pc", d_pc, m_dpc);
    check("d_len", d_len, m_dlen);
    check("int_ack", int_ack, m_ack);
    check("inte", inte, m_inte);
    check("halted", halted, m_halt);
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; int_req = 1'b0; int_vec = 3'd0;
  endtask

  task automatic jump_to(input logic [15:0] a);
    redirect = 1'b1; redirect_pc = a;
    cycle();
    redirect = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    idle_inputs();
    rst = 1'b1;
    model_reset();
    // Wrap: JMP at FFFE advances the PC to 0001.
    mem[16'hFFFE] = 8'hC3; mem[16'hFFFF] = 8'h34;
    // Length walk program at 0000.
    mem[16'h0000] = 8'h3E; mem[16'h0001] = 8'h05;
    mem[16'h0002] = 8'h21; mem[16'h0003] = 8'h34; mem[16'h0004] = 8'h12;
    mem[16'h0005] = 8'h80;
    mem[16'h0006] = 8'hC3; mem[16'h0007] = 8'h00; mem[16'h0008] = 8'h01;
    // HLT test program.
    mem[16'h000E] = 8'hFB; mem[16'h0010] = 8'h76;
    // EI shadow program.
    mem[16'h0020] = 8'hFB;
    // Wrong-path HLT.
    mem[16'h0030] = 8'h76;
    #12;
    @(negedge clk);
    rst = 1'b0;
    check_all();
    check("reset_fetch_addr", fetch_addr, 16'hFFFE);

    cycle();
    check("wrap_d_instr", d_instruction, 24'hC3343E);
    check("wrap_pc", fetch_addr, 16'h0001);

    // Length walk.
    jump_to(16'h0000);
    cycle();
    check("walk0_pc", d_pc, 16'h0000);
    check("walk0_len", d_len, 2'd2);
    check("walk0_mvi", d_instruction, 24'h3E0500);
    cycle();
    check("walk1_pc", d_pc, 16'h0002);
    check("walk1_len", d_len, 2'd3);
    cycle();
    check("walk2_pc", d_pc, 16'h0005);
    check("walk2_len", d_len, 2'd1);
    check("walk2_instr", d_instruction, 24'h800000);

    // Redirect under stall.
    stall = 1'b1;
    jump_to(16'h0100);
    stall = 1'b0;
    check("redir_flush", d_valid, 1'b0);
    check("redir_addr", fetch_addr, 16'h0100);
    cycle();
    check("redir_dispatch", d_pc, 16'h0100);

    // HLT then interrupt.
    jump_to(16'h000E);
    cycle(); cycle(); cycle();
    check("hlt_halted", halted, 1'b1);
    check("hlt_addr", fetch_addr, 16'h0011);
    check("hlt_inte", inte, 1'b1);
    cycle();
    check("hlt_idle_valid", d_valid, 1'b0);
    int_req = 1'b1; int_vec = 3'd7;
    cycle();
    int_req = 1'b0;
    check("irq_instr", d_instruction, 24'hFF0000);
    check("irq_pc", d_pc, 16'h0011);
    check("irq_ack", int_ack, 1'b1);
    check("irq_inte", inte, 1'b0);
    check("irq_halted", halted, 1'b0);
    cycle();
    check("irq_ack_pulse", int_ack, 1'b0);

    // EI shadow with int_req held.
    int_req = 1'b1; int_vec = 3'd2;
    jump_to(16'h0020);
    cycle();
    check("shadow_ei", d_pc, 16'h0020);
    check("shadow_ack0", int_ack, 1'b0);
    cycle();
    check("shadow_next", d_pc, 16'h0021);
    check("shadow_ack1", int_ack, 1'b0);
    cycle();
    check("shadow_rst", d_instruction, 24'hD70000);
    check("shadow_rst_pc", d_pc, 16'h0022);
    check("shadow_ack2", int_ack, 1'b1);
    int_req = 1'b0;

    // Redirect out of a wrong-path HLT.
    jump_to(16'h0030);
    cycle();
    check("wp_halted", halted, 1'b1);
    jump_to(16'h0200);
    check("wp_unhalt", halted, 1'b0);
    cycle();
    check("wp_resume", d_pc, 16'h0200);

    // Randomized traffic.
    for (int i = 0; i < 65536; i++) begin
      case ($urandom_range(0, 15))
        0, 1:    mem[i] = 8'hFB;
        2:       mem[i] = 8'h76;
        3:       mem[i] = 8'hF3;
        default: mem[i] = 8'($urandom);
      endcase
    end
    for (int c = 0; c < 3000; c++) begin
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 16'($urandom);
      int_req     = ($urandom_range(0, 3) == 0);
      int_vec     = 3'($urandom);
      cycle();
    end

    // Asynchronous reset mid-cycle.
    idle_inputs();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("arst_addr", fetch_addr, 16'hFFFE);
    check("arst_valid", d_valid, 1'b0);
    check("arst_instr", d_instruction, 24'h0);
    check("arst_pc", d_pc, 16'h0);
    check("arst_len", d_len, 2'd0);
    check("arst_ack", int_ack, 1'b0);
    check("arst_inte", inte, 1'b0);
    check("arst_halted", halted, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mem[16'hFFFE] = 8'hC3;
    cycle();
    check("arst_wrap", fetch_addr, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Front-end controller for the 8080 pipeline. It owns the program counter and walks the 24-bit instruction window returned by memory. It sizes each instruction as 1, 2 or 3 bytes and dispatches one instruction per cycle into decode. It also applies redirects from later stages, handles HLT, and injects RST instructions for interrupts.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
fetch_addr  out  16  byte address of the instruction window; equals the pc register.
fetch_data  in  24  window at fetch_addr, combinational read: [23:16] opcode, [15:8] low byte, [7:0] high byte.
stall  in  1  decode cannot accept; hold all state and outputs.
redirect  in  1  taken jump/call/ret/rst/pchl from a later stage.
redirect_pc  in  16  new PC, used when redirect=1.
int_req  in  1  level interrupt request.
int_vec  in  3  RST number n for the injected interrupt.
int_ack  out  1  one-cycle pulse when an interrupt is injected.
d_valid  out  1  d_* outputs hold a live instruction.
d_instruction  out  24  dispatched instruction; unused trailing bytes are forced to 0.
d_pc  out  16  address of the instruction; for an injected RST, the return address.
d_len  out  2  1, 2 or 3; 1 for an injected RST.
inte  out  1  interrupt-enable flip-flop.
halted  out  1  state is HALT.

Behaviour:
- Reset (async, on rst=1): pc=RESET_PC; d_valid=0; d_instruction=0; d_pc=0; d_len=0; int_ack=0; inte=0; ei_pending=0; state=RUN.
- States are RUN and HALT. halted=(state==HALT).
- Length decode of fetch_data[23:16]:
  - 3 bytes: LXI 00rp0001, SHLD 22, LHLD 2A, STA 32, LDA 3A, JMP C3, Jccc 11ccc010, CALL CD, Cccc 11ccc100.
  - 2 bytes: MVI 00ddd110, ADI/ACI/SUI/SBI/ANI/XRI/ORI/CPI 11xxx110, OUT D3, IN DB.
  - All other opcodes: 1 byte.
- Per-edge priority (rst aside): redirect > stall > interrupt > normal dispatch.
- Redirect: pc<=redirect_pc; d_valid<=0 (flush); state<=RUN, which cancels a wrong-path HLT; int_ack<=0. Applies even when stall=1.
- Stall (no redirect): pc, d_*, state, inte and ei_pending hold; int_ack<=0.
- Interrupt, taken in RUN or HALT when inte && int_req && !stall && !redirect:
  - d_instruction<={8'hC7|(int_vec<<3),16'h0000}; d_pc<=pc; d_len<=1; d_valid<=1.
  - pc unchanged; inte<=0; ei_pending<=0; int_ack<=1; state<=RUN.
- Normal dispatch (RUN, none of the above):
  - d_instruction<=window masked to len; d_pc<=pc; d_len<=len; d_valid<=1.
  - pc<=pc+len, modulo 2^16: FFFF+3 -> 0002.
  - Opcode 76 (HLT): state<=HALT.
  - Opcode F3 (DI): inte<=0 and ei_pending<=0 at this edge.
  - Opcode FB (EI): ei_pending<=1.
  - inte<=1 at the next dispatch edge after EI, so the instruction following EI always dispatches before any interrupt.
- HALT with no interrupt and no redirect: d_valid<=0; pc holds at HLT address+1; fetch_addr stays stable.
- Output timing: int_ack is high for exactly the cycle after the injecting edge. d_* are registered, giving a latency of 1 cycle from fetch_addr to d_valid.
- EI followed by a stall: ei_pending holds. The enable completes on the next real dispatch.
- A redirect arriving together with int_req: the interrupt is deferred to a later cycle; inte is not consumed.

Decomposition:
- Shared package cpu8080_pkg:
  - opcode constants: OP_HLT, OP_EI, OP_DI, OP_RST_BASE=8'hC7;
  - length enum LEN1/LEN2/LEN3;
  - state enum RUN/HALT.
- Sub-module instr_len: combinational opcode-to-length decode. It is reused by the main pipeline decode.

Test Plan:
- Length walk: memory at 0000 holds 3E 05 | 21 34 12 | 80 | C3 00 01.
  - Expect d_pc = 0000, 0002, 0005, 0006 with d_len 2, 3, 1, 3.
  - Expect d_instruction for MVI = 3E0500.
- Redirect under stall: at d_pc=0005, hold stall=1 and pulse redirect with redirect_pc=0100.
  - Next cycle: d_valid=0, fetch_addr=0100.
  - The following cycle dispatches from 0100.
- HLT then interrupt: 76 at 0010, inte=1.
  - Expect halted=1 and fetch_addr=0011.
  - Raise int_req with int_vec=7: expect d_instruction=FF0000, d_pc=0011, int_ack for 1 cycle, inte=0, halted=0.
- EI shadow: FB, 00, 00 with int_req held high from the start.
  - Expect FB and the first 00 to dispatch.
  - Expect the RST to be injected before the second 00, with d_pc = address of the second 00.
- Wrap and reset: RESET_PC=FFFE, memory C3 at FFFE.
  - Expect next pc = 0001.
  - Assert rst asynchronously mid-cycle: outputs are zero and fetch_addr=FFFE immediately.
- Redirect out of a wrong-path HLT: dispatch 76, then redirect to 0200 on the next cycle.
  - Expect halted drops to 0 and dispatch resumes at 0200.
